// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, rate and parity constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int CLK_FREQ             = 48_000_000;
  localparam int BAUD                 = 9600;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_FREQ / BAUD;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop line synchronizer with falling-edge detect, idles high
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line,
  output logic fall
);

  logic meta;
  logic prev;

  // All three flops reset to the idle level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      line <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      line <= meta;
      prev <= line;
    end
  end

  assign fall = prev & ~line;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: mid-bit sampling, optional parity, framing/break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_ENABLED = 1,
  parameter int PARITY_TYPE    = PARITY_EVEN,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_framing_err,
  output logic                  o_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  rx_state_e             state;
  rx_state_e             state_next;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_err;
  logic                  line;
  logic                  fall;
  logic                  mid_point;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (serial_in),
    .line    (line),
    .fall    (fall)
  );

  // START samples at half a bit; every later state is a whole bit after the previous sample.
  always_comb begin
    state_next = state;
    mid_point  = (state == START) ? (cnt == CNT_HALF) : (cnt == CNT_LAST);
    case (state)
      IDLE:    if (fall) state_next = START;
      START:   if (mid_point) state_next = line ? IDLE : DATA;
      DATA:    if (mid_point && idx == IDX_LAST) state_next = (PARITY_ENABLED != 0) ? PARITY : STOP;
      PARITY:  if (mid_point) state_next = STOP;
      STOP:    if (mid_point) state_next = line ? IDLE : BREAK;
      BREAK:   if (line) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      par_err       <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_parity_err  <= 1'b0;
      o_framing_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      if (state_next != state || state == IDLE || state == BREAK) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        START: begin
          idx     <= '0;
          par_err <= 1'b0;
        end
        DATA: begin
          if (mid_point) begin
            shift <= {line, shift[DATA_WIDTH-1:1]};
            idx   <= idx + 1'b1;
          end
        end
        PARITY: begin
          if (mid_point) par_err <= line ^ (^shift) ^ PARITY_TYPE[0];
        end
        STOP: begin
          if (mid_point) begin
            o_data        <= shift;
            o_valid       <= 1'b1;
            o_parity_err  <= par_err;
            o_framing_err <= ~line;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (16 clk/bit, 8N1 + parity)
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;

  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_framing_err, o_busy;
  logic [7:0] odd_data;
  logic       odd_valid, odd_parity_err, odd_framing_err, odd_busy;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int v0;
  int bc;
  logic       busy_at_valid = 1'bx;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_TYPE(0), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
    .o_framing_err(o_framing_err), .o_busy(o_busy)
  );

  uart_rx #(.DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_TYPE(1), .CLKS_PER_BIT(CPB)) dut_odd (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .o_data(odd_data), .o_valid(odd_valid), .o_parity_err(odd_parity_err),
    .o_framing_err(odd_framing_err), .o_busy(odd_busy)
  );

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vcnt++;
      got_q.push_back(o_data);
      busy_at_valid = o_busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", o_data, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_perr", o_parity_err, 0);
    chk("reset_ferr", o_framing_err, 0);
    chk("reset_busy", o_busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;

    // 1: clean 0xA5, even parity bit 0
    v0 = vcnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t1_count", vcnt - v0, 1);
    chk("t1_data", o_data, 8'hA5);
    chk("t1_perr", o_parity_err, 0);
    chk("t1_ferr", o_framing_err, 0);
    chk("t1_busy_at_valid", busy_at_valid, 0);

    // 2: 0x3C with wrong even parity; odd receiver sees it as correct
    v0 = vcnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t2_count", vcnt - v0, 1);
    chk("t2_data", o_data, 8'h3C);
    chk("t2_perr_even", o_parity_err, 1);
    chk("t2_data_odd", odd_data, 8'h3C);
    chk("t2_perr_odd", odd_parity_err, 0);

    // 3: 5-clk glitch is rejected, then 0x01 (even parity bit 1)
    v0 = vcnt;
    bc = 0;
    serial_in = 1'b0;
    repeat (5) @(posedge clk); #1;
    serial_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_busy === 1'b1) bc++;
    end
    chk("t3_glitch_busy_window", (bc > 0 && bc <= 8), 1);
    chk("t3_glitch_no_valid", vcnt - v0, 0);
    chk("t3_idle_after_glitch", o_busy, 0);
    @(posedge clk); #1;
    send_frame(8'h01, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t3_count", vcnt - v0, 1);
    chk("t3_data", o_data, 8'h01);
    chk("t3_perr", o_parity_err, 0);
    chk("t3_ferr", o_framing_err, 0);

    // 4: 0xFF with stop bit 0, line then held low as a break
    v0 = vcnt;
    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (40 * CPB) @(posedge clk); #1;
    chk("t4_count", vcnt - v0, 1);
    chk("t4_data", o_data, 8'hFF);
    chk("t4_ferr", o_framing_err, 1);
    chk("t4_perr", o_parity_err, 0);
    chk("t4_busy_in_break", o_busy, 1);
    serial_in = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t4_busy_after_break", o_busy, 0);
    repeat (100) @(posedge clk); #1;
    chk("t4_no_extra_valid", vcnt - v0, 1);

    // 5: back-to-back frames, no idle gap
    got_q.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t5_count", got_q.size(), 3);
    chk("t5_data0", got_q[0], 8'h00);
    chk("t5_data1", got_q[1], 8'hFF);
    chk("t5_data2", got_q[2], 8'h55);
    chk("t5_perr", o_parity_err, 0);
    chk("t5_ferr", o_framing_err, 0);

    // 6: reset during data bit 4 of 0x81, then a clean 0x7E
    v0 = vcnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    serial_in = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("t6_busy_before_reset", o_busy, 1);
    reset = 1'b1;
    serial_in = 1'b1;
    #2;
    chk("t6_rst_data", o_data, 0);
    chk("t6_rst_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_perr", o_parity_err, 0);
    chk("t6_rst_ferr", o_framing_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("t6_no_partial_valid", vcnt - v0, 0);
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("t6_count", vcnt - v0, 1);
    chk("t6_data", o_data, 8'h7E);
    chk("t6_perr", o_parity_err, 0);
    chk("t6_ferr", o_framing_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver (serial-in, parallel-out). It is the counterpart of the existing 48 MHz / 9600 bps transmitter.
- Frame: 1 start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, 1 stop bit (1).
- Samples the asynchronous line at mid-bit using its own bit-period counter.
- Presents each received word with a one-cycle valid strobe and error flags, for a downstream FIFO or consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PARITY_ENABLED, 1, 1 = parity bit present between the last data bit and the stop bit.
- PARITY_TYPE, 0, 0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data).
- CLKS_PER_BIT, 5000, clk cycles per bit period (48 MHz / 9600). Must be ≥ 4.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  asynchronous, active-high reset; clears all state.
- serial_in  in  1  asynchronous UART line; idles high.
- o_data  out  DATA_WIDTH  last received word; held until the next o_valid.
- o_valid  out  1  one-cycle pulse when a frame completes; qualifies o_data and the error flags.
- o_parity_err  out  1  parity mismatch on the frame; valid with o_valid, held until the next o_valid. Constant 0 if PARITY_ENABLED = 0.
- o_framing_err  out  1  stop bit sampled as 0; valid with o_valid, held until the next o_valid.
- o_busy  out  1  high from start-edge detection until return to IDLE.

Behaviour:
- Input conditioning:
  - serial_in passes through a 2-flop synchronizer; both flops reset to 1.
  - A falling edge is detected on the synchronized signal (sync_prev = 1, sync = 0).
  - All decoding uses the synchronized signal. Input-to-decision latency is 2 clk.
- Reset values: o_data = 0, o_valid = 0, o_parity_err = 0, o_framing_err = 0, o_busy = 0, state = IDLE, counters = 0.
- Reset mid-frame: aborts immediately. No o_valid for the partial frame.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps. Reloaded to 0 on every state transition.
- Mid-bit point: counter = CLKS_PER_BIT/2 - 1 (integer division) in START; counter = CLKS_PER_BIT-1 in the later states, measured from the START mid-point.
- States:
  - IDLE:
    - A falling edge moves to START, sets o_busy = 1 and clears the counter.
  - START:
    - At the half-bit point, sample the line.
    - If the line is 1 (glitch / false start): go to IDLE, o_busy = 0, no o_valid.
    - If the line is 0: go to DATA with bit index = 0.
  - DATA:
    - At each full-bit point, shift the sample into a shift register LSB-first.
    - When index = DATA_WIDTH-1, go to PARITY if PARITY_ENABLED, else go to STOP.
  - PARITY:
    - At the full-bit point, capture the sample.
    - Compare it with the expected parity of the shifted data, per PARITY_TYPE; record the mismatch.
    - Go to STOP.
  - STOP:
    - At the full-bit point, sample the line.
    - On the next clk: load o_data, o_parity_err and o_framing_err (= ~sample), and pulse o_valid = 1 for exactly one cycle.
    - If the stop sample is 1: go to IDLE, o_busy = 0 in the same cycle as o_valid.
    - If the stop sample is 0: go to BREAK.
  - BREAK:
    - Wait until the synchronized line is 1, then go to IDLE.
    - o_busy stays 1 throughout.
    - Prevents a held-low line (break) from re-triggering frames.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after STOP is accepted. There are no dead cycles beyond the STOP → IDLE transition.
- Falling edges seen while not in IDLE are ignored for start detection.
- Frame-to-valid latency: the o_valid pulse occurs 1 clk after the stop-bit mid-point, plus the 2-clk synchronizer delay relative to the serial line.
- Width rules:
  - Bit index width = clog2(DATA_WIDTH).
  - Counter width = clog2(CLKS_PER_BIT).
  - Parity = XOR-reduce over DATA_WIDTH bits.
- Nothing back-pressures the receiver. A consumer must capture o_data on o_valid; there is no overrun flag.

Decomposition:
- Shared package uart_pkg:
  - state encoding: IDLE, START, DATA, PARITY, STOP, BREAK;
  - default CLK_FREQ = 48_000_000, BAUD = 9600, and derived CLKS_PER_BIT;
  - PARITY_EVEN = 0, PARITY_ODD = 1 (shared with the transmitter side).
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus falling-edge detector, reset to line-idle (1). It is reusable by any future line monitor.
- FSM, counters and shift register stay in uart_rx.

Test Plan (bench uses CLKS_PER_BIT = 16, DATA_WIDTH = 8):
1. Even parity, send 0xA5 (parity bit 0, stop 1) → single o_valid pulse; o_data = 0xA5, o_parity_err = 0, o_framing_err = 0; o_busy falls in the same cycle as o_valid.
2. Send 0x3C with the parity bit forced to 1 → o_valid; o_data = 0x3C, o_parity_err = 1. With PARITY_TYPE = 1, the same frame gives o_parity_err = 0.
3. 5-clk low glitch on an idle line → no o_valid; o_busy high ≤ 8 clk then returns 0. A following valid 0x01 frame is received correctly.
4. Send 0xFF with stop bit 0, then hold the line low for 40 bit times → exactly one o_valid with o_framing_err = 1, o_data = 0xFF. o_busy stays 1 until the line returns high; no further o_valid.
5. Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three o_valid pulses in order with matching data, all error flags 0.
6. Assert reset at data bit 4 of a 0x81 frame, release it, then send 0x7E → no o_valid for 0x81. All outputs are 0 during reset; the next o_valid carries o_data = 0x7E.
